// File: rtl/game_sequencer.sv
// Game-flow controller: sequences attract/play/wave-clear/life-lost/game-over,
// and keeps score, lives, wave and alien march speed. Timers advance on fsync.
module game_sequencer #(
  parameter int START_LIVES      = 3,
  parameter int POINTS_PER_ALIEN = 10,
  parameter int SCORE_W          = 16,
  parameter int BASE_SPEED       = 1,
  parameter int MAX_SPEED        = 8,
  parameter int CLEAR_FRAMES     = 60,
  parameter int OVER_FRAMES      = 120,
  parameter int CNT_W            = 5
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               fsync,
  input  logic               fire,
  input  logic               alien_hit,
  input  logic               alien_reached_paddle,
  input  logic [CNT_W-1:0]   aliens_remaining,
  output logic               field_rst,
  output logic [3:0]         enemy_speed,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [7:0]         wave,
  output logic [2:0]         state,
  output logic               show_gameover
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PLAY       = 3'd1,
    S_WAVE_CLEAR = 3'd2,
    S_LIFE_LOST  = 3'd3,
    S_GAME_OVER  = 3'd4
  } state_e;

  localparam int FRAME_MAX = (CLEAR_FRAMES > OVER_FRAMES) ? CLEAR_FRAMES : OVER_FRAMES;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam logic [SCORE_W:0] SCORE_SAT = {1'b0, {SCORE_W{1'b1}}};

  state_e               state_q, state_d;
  logic                 field_rst_q, field_rst_d;
  logic [3:0]           speed_q, speed_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           lives_q, lives_d;
  logic [7:0]           wave_q, wave_d;
  logic                 show_q, show_d;
  logic                 fire_q;
  logic                 armed_q, armed_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic                 fire_edge;
  logic                 timed_state;
  logic [SCORE_W:0]     score_sum;
  logic [7:0]           wave_inc;
  logic [8:0]           speed_sum;

  assign fire_edge   = fire & ~fire_q;
  assign timed_state = (state_q == S_WAVE_CLEAR) || (state_q == S_LIFE_LOST) ||
                       (state_q == S_GAME_OVER);
  assign score_sum   = {1'b0, score_q} + (SCORE_W + 1)'(POINTS_PER_ALIEN);
  assign wave_inc    = (wave_q == 8'hFF) ? wave_q : wave_q + 8'd1;
  assign speed_sum   = 9'(BASE_SPEED) + {1'b0, wave_inc};

  always_comb begin
    state_d     = state_q;
    speed_d     = speed_q;
    score_d     = score_q;
    lives_d     = lives_q;
    wave_d      = wave_q;
    armed_d     = armed_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (fire_edge) begin
          score_d = '0;
          lives_d = 3'(START_LIVES);
          wave_d  = '0;
          speed_d = 4'(BASE_SPEED);
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (fsync) armed_d = 1'b1;
        if (alien_hit)
          score_d = (score_sum > SCORE_SAT) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        if (alien_reached_paddle) begin
          if (lives_q == 3'd1) begin
            lives_d = 3'd0;
            state_d = S_GAME_OVER;
          end else begin
            lives_d = lives_q - 3'd1;
            state_d = S_LIFE_LOST;
          end
        end else if (armed_q && (aliens_remaining == '0)) begin
          wave_d  = wave_inc;
          speed_d = (speed_sum > 9'(MAX_SPEED)) ? 4'(MAX_SPEED) : speed_sum[3:0];
          state_d = S_WAVE_CLEAR;
        end
      end
      S_WAVE_CLEAR, S_LIFE_LOST: begin
        if (frame_cnt_q >= FRAME_W'(CLEAR_FRAMES)) state_d = S_PLAY;
      end
      S_GAME_OVER: begin
        if (fire_edge && (frame_cnt_q >= FRAME_W'(OVER_FRAMES))) begin
          score_d = '0;
          lives_d = 3'(START_LIVES);
          wave_d  = '0;
          speed_d = 4'(BASE_SPEED);
          state_d = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // armed only survives while staying in PLAY; re-entry must see a fresh fsync
    if (state_d != S_PLAY) armed_d = 1'b0;

    if (state_d != state_q)
      frame_cnt_d = '0;
    else if (fsync && timed_state && (frame_cnt_q != {FRAME_W{1'b1}}))
      frame_cnt_d = frame_cnt_q + 1'b1;

    field_rst_d = (state_d != S_PLAY);
    show_d      = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      field_rst_q <= 1'b1;
      speed_q     <= 4'(BASE_SPEED);
      score_q     <= '0;
      lives_q     <= 3'(START_LIVES);
      wave_q      <= '0;
      show_q      <= 1'b0;
      fire_q      <= 1'b0;
      armed_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      field_rst_q <= field_rst_d;
      speed_q     <= speed_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      wave_q      <= wave_d;
      show_q      <= show_d;
      fire_q      <= fire;
      armed_q     <= armed_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign field_rst     = field_rst_q;
  assign enemy_speed   = speed_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign wave          = wave_q;
  assign state         = state_q;
  assign show_gameover = show_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: expected values are queued as stimulus is
// driven, then popped and checked against the DUT outputs.
module tb_game_sequencer;

  localparam int F_STATE = 0;
  localparam int F_FRST  = 1;
  localparam int F_SCORE = 2;
  localparam int F_LIVES = 3;
  localparam int F_WAVE  = 4;
  localparam int F_SPEED = 5;
  localparam int F_SHOW  = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fsync;
  logic        fire;
  logic        alien_hit;
  logic        alien_reached_paddle;
  logic [4:0]  aliens_remaining;
  logic        field_rst;
  logic [3:0]  enemy_speed;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [7:0]  wave;
  logic [2:0]  state;
  logic        show_gameover;

  int    n_total = 0;
  int    n_pass  = 0;
  int    n_fail  = 0;
  int    exp_score = 0;
  string tag_q[$];
  int    field_q[$];
  int    exp_q[$];

  game_sequencer dut (
    .pixel_clk            (clk),
    .rst_n                (rst_n),
    .fsync                (fsync),
    .fire                 (fire),
    .alien_hit            (alien_hit),
    .alien_reached_paddle (alien_reached_paddle),
    .aliens_remaining     (aliens_remaining),
    .field_rst            (field_rst),
    .enemy_speed          (enemy_speed),
    .score                (score),
    .lives                (lives),
    .wave                 (wave),
    .state                (state),
    .show_gameover        (show_gameover)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int f);
    case (f)
      F_STATE: return 32'(state);
      F_FRST:  return 32'(field_rst);
      F_SCORE: return 32'(score);
      F_LIVES: return 32'(lives);
      F_WAVE:  return 32'(wave);
      F_SPEED: return 32'(enemy_speed);
      default: return 32'(show_gameover);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(string tag, int f, int e);
    tag_q.push_back(tag);
    field_q.push_back(f);
    exp_q.push_back(e);
  endtask

  task automatic drain(string step);
    string       t;
    int          f;
    int          e;
    logic [31:0] obs;
    while (tag_q.size() > 0) begin
      t   = tag_q.pop_front();
      f   = field_q.pop_front();
      e   = exp_q.pop_front();
      obs = observe(f);
      n_total++;
      assert (obs === 32'(e)) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
      end
    end
    $display("[%0t] %s: state=%0d score=%0d lives=%0d wave=%0d speed=%0d",
             $time, step, state, score, lives, wave, enemy_speed);
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      tick();
    end
  endtask

  task automatic hit_once();
    alien_hit = 1'b1;
    tick();
    alien_hit = 1'b0;
    exp_score = (exp_score + 10 > 65535) ? 65535 : exp_score + 10;
  endtask

  initial begin
    rst_n = 1'b0; fsync = 1'b0; fire = 1'b0; alien_hit = 1'b0;
    alien_reached_paddle = 1'b0; aliens_remaining = 5'd5;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    expect_v("rst_state", F_STATE, 0);  expect_v("rst_frst", F_FRST, 1);
    expect_v("rst_score", F_SCORE, 0);  expect_v("rst_lives", F_LIVES, 3);
    expect_v("rst_wave", F_WAVE, 0);    expect_v("rst_speed", F_SPEED, 1);
    expect_v("rst_show", F_SHOW, 0);
    drain("reset");

    // start from IDLE
    fire = 1'b1;
    tick();
    fire = 1'b0;
    expect_v("start_state", F_STATE, 1); expect_v("start_frst", F_FRST, 0);
    expect_v("start_lives", F_LIVES, 3); expect_v("start_score", F_SCORE, 0);
    expect_v("start_speed", F_SPEED, 1);
    drain("start");

    for (int i = 0; i < 3; i++) hit_once();
    expect_v("score_30", F_SCORE, exp_score);
    expect_v("score_30_lit", F_SCORE, 30);
    drain("three hits");
    for (int i = 0; i < 6555; i++) hit_once();
    expect_v("score_sat", F_SCORE, 65535);
    drain("score saturation");

    // zero aliens before any fsync must not clear the wave
    aliens_remaining = 5'd0;
    tick(); tick(); tick();
    expect_v("unarmed_hold", F_STATE, 1);
    drain("unarmed hold");

    for (int w = 1; w <= 8; w++) begin
      aliens_remaining = 5'd0;
      frames(1);
      aliens_remaining = 5'd5;
      expect_v("wc_state", F_STATE, 2);
      expect_v("wc_wave", F_WAVE, w);
      expect_v("wc_speed", F_SPEED, (w + 1 > 8) ? 8 : w + 1);
      expect_v("wc_frst", F_FRST, 1);
      drain("wave clear");
      if (w == 1) begin
        frames(59);
        expect_v("wc_59_hold", F_STATE, 2);
        drain("wave clear 59 frames");
        frames(1);
      end else begin
        frames(60);
      end
      expect_v("wc_back_play", F_STATE, 1);
      expect_v("wc_back_frst", F_FRST, 0);
      drain("back to play");
    end

    // paddle hit wins over armed wave clear
    aliens_remaining = 5'd0;
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    alien_reached_paddle = 1'b1;
    tick();
    alien_reached_paddle = 1'b0;
    aliens_remaining = 5'd5;
    expect_v("ll_state", F_STATE, 3); expect_v("ll_lives", F_LIVES, 2);
    expect_v("ll_wave", F_WAVE, 8);   expect_v("ll_speed", F_SPEED, 8);
    drain("life lost");
    frames(59);
    expect_v("ll_59_hold", F_STATE, 3);
    drain("life lost 59 frames");
    frames(1);
    expect_v("ll_back_play", F_STATE, 1);
    expect_v("ll_score", F_SCORE, exp_score);
    drain("life lost done");

    alien_reached_paddle = 1'b1;
    tick();
    alien_reached_paddle = 1'b0;
    expect_v("ll2_lives", F_LIVES, 1);
    drain("second life lost");
    frames(60);
    alien_reached_paddle = 1'b1;
    tick();
    alien_reached_paddle = 1'b0;
    expect_v("go_state", F_STATE, 4); expect_v("go_lives", F_LIVES, 0);
    expect_v("go_show", F_SHOW, 1);   expect_v("go_frst", F_FRST, 1);
    drain("game over");

    frames(10);
    fire = 1'b1; tick(); fire = 1'b0; tick();
    expect_v("go_fire10_ignored", F_STATE, 4);
    drain("fire at 10 frames");
    frames(109);
    fire = 1'b1; tick(); fire = 1'b0; tick();
    expect_v("go_fire119_ignored", F_STATE, 4);
    drain("fire at 119 frames");
    frames(1);
    fire = 1'b1;
    tick();
    fire = 1'b0;
    exp_score = 0;
    expect_v("rs_state", F_STATE, 1); expect_v("rs_show", F_SHOW, 0);
    expect_v("rs_lives", F_LIVES, 3); expect_v("rs_score", F_SCORE, 0);
    expect_v("rs_wave", F_WAVE, 0);   expect_v("rs_speed", F_SPEED, 1);
    drain("restart");

    hit_once(); hit_once();
    expect_v("rs_score20", F_SCORE, exp_score);
    drain("hits after restart");
    aliens_remaining = 5'd0;
    frames(1);
    aliens_remaining = 5'd5;
    expect_v("rs_wc_state", F_STATE, 2);
    expect_v("rs_wc_wave", F_WAVE, 1);
    drain("wave clear before reset");
    frames(5);

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    expect_v("arst_state", F_STATE, 0); expect_v("arst_frst", F_FRST, 1);
    expect_v("arst_score", F_SCORE, 0); expect_v("arst_wave", F_WAVE, 0);
    expect_v("arst_speed", F_SPEED, 1); expect_v("arst_lives", F_LIVES, 3);
    expect_v("arst_show", F_SHOW, 0);
    drain("async reset");
    tick();
    rst_n = 1'b1;
    tick();
    expect_v("post_rst_idle", F_STATE, 0);
    drain("after reset release");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
